main_host_driver: RTL and testbench

Host-side sequencer wrapped around the generated `main` accelerator. It accepts a job (init value plus DEPTH array preload words) over valid/ready streams and loads the array through main's controlArr port. It then pulses r_enable, waits for w_enable with a timeout, returns result and cycle count, and finally streams the whole array back out. It is the only block that drives main's start and array-control inputs.

---
 rtl/main_host_pkg.sv | 6 +
 rtl/main_host_fsm.sv | 78 +++++++
 rtl/main_host_driver.sv | 96 +++++++++
 tb/tb_main_host_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/main_host_pkg.sv
// main_host_pkg: shared state encoding and default sizes for the main host driver
package main_host_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESULT, DRAIN} state_e;
endpackage

// File: rtl/main_host_fsm.sv
// main_host_fsm: job sequencing state, array index and saturating wait-cycle counter
module main_host_fsm
    import main_host_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = 1,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    input  logic              ld_valid,
    input  logic              w_enable,
    input  logic              res_ready,
    input  logic              rd_ready,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              last_o,
    output logic              tmo_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last, tmo;

    assign last    = idx_q == ADDR_W'(DEPTH - 1);
    assign tmo     = cnt_q == CNT_W'(TIMEOUT - 1);
    assign state_o = state_q;
    assign idx_o   = idx_q;
    assign cnt_o   = cnt_q;
    assign last_o  = last;
    assign tmo_o   = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (job_valid) begin
                state_d = LOAD;
                idx_d   = '0;
            end
            LOAD: if (ld_valid) begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                state_d = last ? START : LOAD;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (w_enable || tmo) state_d = RESULT;
                  else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            RESULT: if (res_ready) begin
                state_d = DRAIN;
                idx_d   = '0;
            end
            DRAIN: if (rd_ready) begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                state_d = last ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/main_host_driver.sv
// main_host_driver: host sequencer that preloads main's array, starts it, times completion
// and streams the result and the whole array back out.
module main_host_driver
    import main_host_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_init,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              r_enable,
    output logic [DATA_W-1:0] init_i,
    output logic              controlArr,
    output logic              controlArrWEnable_a,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    output logic [DATA_W-1:0] controlArrWData_a,
    input  logic [DATA_W-1:0] controlArrRData_a,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] result
);
    logic [2:0]        state;
    state_e            st;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic              last, tmo, done;
    logic [DATA_W-1:0] init_q, init_d, res_data_q, res_data_d;
    logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
    logic              res_timeout_q, res_timeout_d;

    main_host_fsm #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_fsm (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .ld_valid(ld_valid),
        .w_enable(w_enable), .res_ready(res_ready), .rd_ready(rd_ready),
        .state_o(state), .idx_o(idx), .cnt_o(cnt), .last_o(last), .tmo_o(tmo)
    );

    assign st   = state_e'(state);
    // w_enable takes priority over a timeout landing on the same cycle
    assign done = (st == WAIT) && (w_enable || tmo);

    always_comb begin
        init_d        = (st == IDLE && job_valid) ? job_init : init_q;
        res_data_d    = done ? (w_enable ? result : '0) : res_data_q;
        res_cycles_d  = done ? (w_enable ? cnt : CNT_W'(TIMEOUT)) : res_cycles_q;
        res_timeout_d = done ? !w_enable : res_timeout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q        <= '0;
            res_data_q    <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            init_q        <= init_d;
            res_data_q    <= res_data_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign job_ready           = st == IDLE;
    assign ld_ready            = st == LOAD;
    assign r_enable            = st == START;
    assign res_valid           = st == RESULT;
    assign rd_valid            = st == DRAIN;
    assign controlArr          = ld_ready || rd_valid;
    assign controlArrWEnable_a = ld_ready && ld_valid;
    assign controlArrAddr_a    = controlArr ? idx : '0;
    assign controlArrWData_a   = ld_ready ? ld_data : '0;
    assign rd_data             = rd_valid ? controlArrRData_a : '0;
    assign rd_last             = rd_valid && last;
    assign init_i              = init_q;
    assign res_data            = res_data_q;
    assign res_cycles          = res_cycles_q;
    assign res_timeout         = res_timeout_q;
endmodule

// File: tb/tb_main_host_driver.sv
// tb_main_host_driver: randomized jobs against a stub main accelerator, checked against
// a job-level model of result, cycle count and readback contents.
module tb_main_host_driver;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int TMO = 16;
    localparam int CW = 32;
    localparam int NEVER = 100000;

    logic          clk = 0, rst_n = 0;
    logic          job_valid = 0, job_ready, ld_valid = 0, ld_ready;
    logic [DW-1:0] job_init = 0, ld_data = 0;
    logic          res_valid, res_ready = 0, res_timeout;
    logic [DW-1:0] res_data;
    logic [CW-1:0] res_cycles;
    logic          rd_valid, rd_ready = 0, rd_last;
    logic [DW-1:0] rd_data;
    logic          r_enable, controlArr, controlArrWEnable_a;
    logic [DW-1:0] init_i, controlArrWData_a, controlArrRData_a;
    logic [AW-1:0] controlArrAddr_a;
    logic          w_enable;
    logic [DW-1:0] result;

    int checks = 0, errors = 0;

    main_host_driver #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready), .job_init(job_init),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cycles(res_cycles),
        .res_timeout(res_timeout), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .r_enable(r_enable), .init_i(init_i), .controlArr(controlArr),
        .controlArrWEnable_a(controlArrWEnable_a), .controlArrAddr_a(controlArrAddr_a),
        .controlArrWData_a(controlArrWData_a), .controlArrRData_a(controlArrRData_a),
        .w_enable(w_enable), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stub main: done 'lat' WAIT cycles after r_enable; result = init + sum(array), array ^= init
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s;
    int            lat = NEVER, k = 0;
    logic          busy = 0;
    assign controlArrRData_a = mem[controlArrAddr_a];
    initial begin w_enable = 0; result = 0; end
    always @(posedge clk) begin
        if (!rst_n) begin
            busy <= 0; w_enable <= 0; k <= 0;
        end else begin
            if (controlArr && controlArrWEnable_a) mem[controlArrAddr_a] <= controlArrWData_a;
            if (r_enable) begin k <= 0; busy <= 1; w_enable <= 0; end
            else if (busy) k <= k + 1;
            if ((r_enable && lat == 0) || (!r_enable && busy && !w_enable && k + 1 == lat)) begin
                s = init_i;
                for (int i = 0; i < DEPTH; i++) s = s + mem[i];
                result <= s;
                w_enable <= 1;
                busy <= 0;
                for (int i = 0; i < DEPTH; i++) mem[i] <= mem[i] ^ init_i;
            end
        end
    end

    // Job-level model expectations
    logic [DW-1:0] pre [DEPTH];
    logic [DW-1:0] exp_rd [DEPTH];
    logic [DW-1:0] exp_init, exp_res;
    logic [CW-1:0] exp_cyc;
    logic          exp_to;
    logic [DW-1:0] got_res, got_rd [DEPTH];
    logic [CW-1:0] got_cyc;
    logic          got_to;

    // Per-cycle compare process
    int   wr_n = 0, rd_n = 0;
    logic prev_r = 0;
    always @(negedge clk) begin
        if (job_valid && job_ready) begin wr_n = 0; rd_n = 0; end
        if (!controlArr) begin
            chk("idle_bus", {controlArrWEnable_a, ld_ready, rd_valid, controlArrAddr_a}, 0);
            chk("idle_wdata", controlArrWData_a, 0);
        end
        if (ld_ready) begin
            chk("wen", controlArrWEnable_a, ld_valid);
            if (ld_valid) begin
                chk("wr_idx_range", wr_n < DEPTH, 1);
                if (wr_n < DEPTH) begin
                    chk("waddr", controlArrAddr_a, wr_n);
                    chk("wdata", controlArrWData_a, pre[wr_n]);
                end
                wr_n++;
            end
        end
        if (r_enable) begin
            chk("r_pulse", prev_r, 0);
            chk("init_i", init_i, exp_init);
            chk("start_own", controlArr, 0);
        end
        prev_r = r_enable;
        if (res_valid) begin
            chk("res_data", res_data, exp_res);
            chk("res_cycles", res_cycles, exp_cyc);
            chk("res_timeout", res_timeout, exp_to);
        end
        if (rd_valid) begin
            chk("rd_idx_range", rd_n < DEPTH, 1);
            if (rd_n < DEPTH) begin
                chk("rd_data", rd_data, exp_rd[rd_n]);
                chk("rd_last", rd_last, rd_n == DEPTH - 1);
                chk("rd_addr", {controlArr, controlArrWEnable_a, controlArrAddr_a}, {1'b1, 1'b0, AW'(rd_n)});
            end
            if (rd_ready) rd_n++;
        end
    end

    task automatic set_model(input logic [DW-1:0] init, input int l);
        logic [DW-1:0] sum;
        sum = init;
        for (int i = 0; i < DEPTH; i++) sum = sum + pre[i];
        exp_init = init;
        exp_res  = (l < TMO) ? sum : '0;
        exp_cyc  = (l < TMO) ? CW'(l) : CW'(TMO);
        exp_to   = !(l < TMO);
        for (int i = 0; i < DEPTH; i++) exp_rd[i] = (l < TMO) ? pre[i] ^ init : pre[i];
        lat = l;
    endtask

    task automatic issue_and_load(input logic [DW-1:0] init, input bit bp);
        int t;
        job_valid = 1; job_init = init;
        t = 0;
        while (!job_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk("job_ready_wait", job_ready, 1);
        @(posedge clk); #1;
        job_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bp) begin @(posedge clk); #1; end
            ld_valid = 1; ld_data = pre[i];
            t = 0;
            while (!ld_ready && t < 50) begin @(posedge clk); #1; t++; end
            chk("ld_ready_wait", ld_ready, 1);
            @(posedge clk); #1;
            ld_valid = 0;
        end
    endtask

    task automatic run_job(input logic [DW-1:0] init, input int l, input bit bp, input int res_dly, input int rd_stall);
        int t;
        set_model(init, l);
        issue_and_load(init, bp);
        t = 0;
        while (!res_valid && t < TMO + 20) begin @(posedge clk); #1; t++; end
        chk("res_valid_wait", res_valid, 1);
        repeat (res_dly) begin @(posedge clk); #1; end
        got_res = res_data; got_cyc = res_cycles; got_to = res_timeout;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            repeat (rd_stall) begin @(posedge clk); #1; end
            t = 0;
            while (!rd_valid && t < 50) begin @(posedge clk); #1; t++; end
            chk("rd_valid_wait", rd_valid, 1);
            got_rd[i] = rd_data;
            rd_ready = 1;
            @(posedge clk); #1;
            rd_ready = 0;
        end
        chk("b2b_job_ready", job_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #23;
        chk("rst_ready", job_ready, 1);
        chk("rst_ctl", {ld_ready, res_valid, rd_valid, rd_last, r_enable, controlArr, controlArrWEnable_a, res_timeout}, 0);
        chk("rst_data", init_i | res_data | rd_data | controlArrWData_a, 0);
        @(posedge clk); #1 rst_n = 1;

        // Directed: init 5, preload 1..4, done after 3 WAIT cycles
        for (int i = 0; i < DEPTH; i++) pre[i] = i + 1;
        run_job(5, 3, 1, 5, 3);
        chk("lit_res", got_res, 64'd15);
        chk("lit_cyc", got_cyc, 3);
        chk("lit_to", got_to, 0);
        chk("lit_rd0", got_rd[0], 4);
        chk("lit_rd1", got_rd[1], 7);
        chk("lit_rd2", got_rd[2], 6);
        chk("lit_rd3", got_rd[3], 1);

        // Directed: never completes -> timeout, readback unchanged
        for (int i = 0; i < DEPTH; i++) pre[i] = 10 * (i + 1);
        run_job(9, NEVER, 0, 0, 0);
        chk("lit_to_res", got_res, 0);
        chk("lit_to_cyc", got_cyc, TMO);
        chk("lit_to_flag", got_to, 1);
        chk("lit_to_rd3", got_rd[3], 40);

        // Boundaries: done on the timeout cycle wins; done on the first WAIT cycle; negative init
        run_job(64'd3, TMO - 1, 0, 1, 0);
        chk("lit_edge_cyc", got_cyc, TMO - 1);
        chk("lit_edge_to", got_to, 0);
        run_job(64'd7, 0, 0, 0, 1);
        chk("lit_zero_cyc", got_cyc, 0);
        run_job(-64'sd5, 5, 0, 0, 0);
        chk("lit_neg_res", got_res, 64'd95);

        // Reset during WAIT abandons the job immediately
        set_model(64'd5, NEVER);
        issue_and_load(64'd5, 0);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1;
        chk("mid_rst_ready", job_ready, 1);
        chk("mid_rst_ctl", {ld_ready, res_valid, rd_valid, rd_last, r_enable, controlArr, controlArrWEnable_a, res_timeout}, 0);
        chk("mid_rst_data", init_i | res_data | res_cycles | rd_data, 0);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < DEPTH; i++) pre[i] = i + 1;
        run_job(5, 3, 0, 0, 0);
        chk("post_rst_res", got_res, 64'd15);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            for (int i = 0; i < DEPTH; i++) pre[i] = {$urandom, $urandom};
            run_job({$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, TMO - 1),
                    1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
